word_serializer: RTL and testbench

//   Consumes the 6-bit word registered by the input-capture flops and sends it
//   out on one pin as a framed, LSB-first serial stream (start/data/stop).

---
 rtl/word_serializer.sv | 128 ++++++++++++
 tb/tb_word_serializer.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/word_serializer.sv
// word_serializer: framed, LSB-first serial transmitter with a ready/load handshake.
// Define PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module word_serializer #(
  parameter int DATA_W       = 6,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_in,
  input  logic              load,
  output logic              ready,
  output logic              tx,
  output logic              busy,
  output logic              frame_done
);

  localparam int DIV_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

`ifdef PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t            state, state_n;
  logic [DIV_W-1:0]  div, div_n;
  logic [BIT_W-1:0]  bit_cnt, bit_cnt_n;
  logic [DATA_W-1:0] shift, shift_n;
  logic              tx_n, frame_done_n, accept;
`ifdef PARITY_EN
  logic              parity, parity_n;
`endif

  assign accept = load && ready;

  // Next-state logic: each non-idle state lasts CLKS_PER_BIT clocks
  always_comb begin
    state_n   = state;
    div_n     = div;
    bit_cnt_n = bit_cnt;
    shift_n   = shift;
`ifdef PARITY_EN
    parity_n  = accept ? ^data_in : parity;
`endif
    if (state == IDLE) begin
      if (accept) begin
        state_n   = START;
        shift_n   = data_in;
        div_n     = '0;
        bit_cnt_n = '0;
      end
    end else if (div != DIV_LAST) begin
      div_n = div + 1'b1;
    end else begin
      div_n = '0;
      case (state)
        START: begin
          state_n   = DATA;
          bit_cnt_n = '0;
        end
        DATA: begin
          shift_n = shift >> 1;
          if (bit_cnt == BIT_LAST) begin
`ifdef PARITY_EN
            state_n = PARITY;
`else
            state_n = STOP;
`endif
          end else begin
            bit_cnt_n = bit_cnt + 1'b1;
          end
        end
`ifdef PARITY_EN
        PARITY:  state_n = STOP;
`endif
        STOP:    state_n = IDLE;
        default: state_n = IDLE;
      endcase
    end
  end

  // Outputs are derived from the next state so they can be registered without lag
  always_comb begin
    tx_n = 1'b1;
    case (state_n)
      START:   tx_n = 1'b0;
      DATA:    tx_n = shift_n[0];
`ifdef PARITY_EN
      PARITY:  tx_n = parity_n;
`endif
      default: tx_n = 1'b1;
    endcase
    frame_done_n = (state_n == STOP) && (div_n == DIV_LAST);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      div        <= '0;
      bit_cnt    <= '0;
      shift      <= '0;
      tx         <= 1'b1;
      ready      <= 1'b1;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_n;
      div        <= div_n;
      bit_cnt    <= bit_cnt_n;
      shift      <= shift_n;
      tx         <= tx_n;
      ready      <= (state_n == IDLE);
      busy       <= (state_n != IDLE);
      frame_done <= frame_done_n;
    end
  end

`ifdef PARITY_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) parity <= 1'b0;
    else       parity <= parity_n;
  end
`endif

endmodule

// File: tb/tb_word_serializer.sv
// tb_word_serializer: scoreboard bench for word_serializer at CLKS_PER_BIT=4 and =1.
// Honours PARITY_EN when defined for the whole build.
module tb_word_serializer;

`ifdef PARITY_EN
  localparam int PAR_BITS = 1;
`else
  localparam int PAR_BITS = 0;
`endif
  localparam int FLEN0 = (6 + 2 + PAR_BITS) * 4;

  typedef struct packed {
    logic tx;
    logic done;
    logic ready;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] data0 = '0, data1 = '0;
  logic       load0 = 1'b0, load1 = 1'b0;
  logic       ready0, tx0, busy0, done0;
  logic       ready1, tx1, busy1, done1;

  exp_t sb0[$];
  exp_t sb1[$];
  int   numChecks = 0;
  int   numFails  = 0;

  always #5 clk = ~clk;

  word_serializer #(.DATA_W(6), .CLKS_PER_BIT(4)) dut0 (
    .clk(clk), .reset(reset), .data_in(data0), .load(load0),
    .ready(ready0), .tx(tx0), .busy(busy0), .frame_done(done0)
  );

  word_serializer #(.DATA_W(6), .CLKS_PER_BIT(1)) dut1 (
    .clk(clk), .reset(reset), .data_in(data1), .load(load1),
    .ready(ready1), .tx(tx1), .busy(busy1), .frame_done(done1)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    numChecks++;
    if (obs !== exp) begin
      numFails++;
      $display("[TB] FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  // Expected per-clock view of a whole frame, built from the word itself
  task automatic pushFrame(input int which, input logic [5:0] d, input int cpb);
    exp_t e;
    logic [5:0] w;
    w = d;
    for (int b = 0; b < 8 + PAR_BITS; b++) begin
      for (int c = 0; c < cpb; c++) begin
        e.ready = 1'b0;
        e.done  = 1'b0;
        if (b == 0)                e.tx = 1'b0;
        else if (b <= 6)           e.tx = w[b-1];
        else if (b == 7 && PAR_BITS == 1) e.tx = ^w;
        else begin
          e.tx   = 1'b1;
          e.done = (c == cpb - 1);
        end
        if (which == 0) sb0.push_back(e);
        else            sb1.push_back(e);
      end
    end
  endtask

  task automatic applyStimulus(input int which, input logic [5:0] d);
    if (which == 0) begin
      data0 = d;
      load0 = 1'b1;
      pushFrame(0, d, 4);
    end else begin
      data1 = d;
      load1 = 1'b1;
      pushFrame(1, d, 1);
    end
  endtask

  // Empty scoreboard means the serializer should be idle
  task automatic checkCycles(input int n);
    exp_t e0, e1;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (sb0.size() > 0) e0 = sb0.pop_front();
      else begin e0.tx = 1'b1; e0.done = 1'b0; e0.ready = 1'b1; end
      if (sb1.size() > 0) e1 = sb1.pop_front();
      else begin e1.tx = 1'b1; e1.done = 1'b0; e1.ready = 1'b1; end
      checkOutput("tx0", 32'(tx0), 32'(e0.tx));
      checkOutput("frame_done0", 32'(done0), 32'(e0.done));
      checkOutput("ready0", 32'(ready0), 32'(e0.ready));
      checkOutput("busy0", 32'(busy0), 32'(!e0.ready));
      checkOutput("tx1", 32'(tx1), 32'(e1.tx));
      checkOutput("frame_done1", 32'(done1), 32'(e1.done));
      checkOutput("ready1", 32'(ready1), 32'(e1.ready));
      checkOutput("busy1", 32'(busy1), 32'(!e1.ready));
    end
  endtask

  initial begin
    // Reset for three clocks, then confirm idle outputs
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    checkCycles(2);

    // Single frame of 6'b101101
    applyStimulus(0, 6'b101101);
    checkCycles(1);
    load0 = 1'b0;
    checkCycles(FLEN0 - 1);
    checkCycles(2);

    // load held high: second frame follows one idle cycle later
    applyStimulus(0, 6'h3F);
    checkCycles(FLEN0);
    data0 = 6'h00;
    pushFrame(0, 6'h00, 4);
    sb0.push_front('{tx: 1'b1, done: 1'b0, ready: 1'b1});
    checkCycles(2);
    load0 = 1'b0;
    checkCycles(FLEN0 - 1);
    checkCycles(2);

    // Mid-frame data change and load pulse are ignored
    applyStimulus(0, 6'h12);
    checkCycles(1);
    load0 = 1'b0;
    checkCycles(8);
    data0 = 6'h3F;
    load0 = 1'b1;
    checkCycles(1);
    load0 = 1'b0;
    checkCycles(FLEN0 - 10);
    checkCycles(4);

    // Asynchronous reset during the data phase
    applyStimulus(0, 6'h2D);
    checkCycles(1);
    load0 = 1'b0;
    checkCycles(11);
    sb0.delete();
    #2 reset = 1'b1;
    #1;
    checkOutput("async_tx0", 32'(tx0), 32'd1);
    checkOutput("async_ready0", 32'(ready0), 32'd1);
    checkOutput("async_busy0", 32'(busy0), 32'd0);
    checkOutput("async_done0", 32'(done0), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    checkCycles(1);
    applyStimulus(0, 6'h01);
    checkCycles(1);
    load0 = 1'b0;
    checkCycles(FLEN0 - 1);
    checkCycles(2);

    // One clock per bit on the second instance
    applyStimulus(1, 6'h2A);
    checkCycles(1);
    load1 = 1'b0;
    checkCycles(7 + PAR_BITS);
    checkCycles(3);

    checkOutput("sb0_drained", 32'(sb0.size()), 32'd0);
    checkOutput("sb1_drained", 32'(sb1.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
    $finish;
  end

endmodule
